// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and FSM state encoding
// Purpose : data width shared by master and slave, master FSM states.
// Ports   : none (package).
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK half-period tick generator
// Purpose : pulses o_tick once every CLK_DIV clk cycles while enabled.
// Ports   : clk, reset_n (async, active low)
//           i_en   - run the counter; counter is held at 0 while low
//           o_tick - one-cycle pulse at the end of each half-period
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_tick
);

  // Keep at least one bit so CLK_DIV=1 still has a legal counter.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The first tick lands CLK_DIV cycles after enable rises.
  assign o_tick = i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte full-duplex SPI master, LSB first
// Purpose : turns a start/byte request into one 8-bit SPI transfer.
//           SCLK idles low, CS active low, MOSI changes on SCLK rise,
//           MISO sampled on SCLK fall.
// Ports   : clk, reset_n (async, active low)
//           start              - request, only looked at while idle
//           masterDataToSend   - byte to transmit, latched on accept
//           masterDataReceived - received byte, updated with done
//           busy, done         - transfer in progress / end pulse
//           SCLK, CS, MOSI     - registered bus outputs
//           MISO               - serial data from the slave
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SPI_DATA_W-1:0] masterDataToSend,
  output logic [SPI_DATA_W-1:0] masterDataReceived,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam logic [2:0] LAST_BIT = 3'(SPI_DATA_W - 1);

  spi_state_t            r_state;
  logic [SPI_DATA_W-1:0] r_tx;
  logic [SPI_DATA_W-1:0] r_rx;
  logic [SPI_DATA_W-1:0] r_rx_out;
  logic [2:0]            r_bit_cnt;
  logic                  r_sclk;
  logic                  r_cs;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_tick;
  logic                  w_clk_en;

  assign w_clk_en = (r_state != ST_IDLE);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_clk_en),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_out  <= '0;
      r_bit_cnt <= '0;
      r_sclk    <= 1'b0;
      r_cs      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_SETUP;
            r_tx      <= masterDataToSend;
            r_rx      <= '0;
            r_bit_cnt <= '0;
            r_cs      <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        ST_SETUP: begin
          // The first rising edge is also the SETUP -> SHIFT transition.
          if (w_tick) begin
            r_state <= ST_SHIFT;
            r_sclk  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              // Bit 0 was already on MOSI since SETUP; advance only on rises 2..8.
              if (r_bit_cnt != 3'd0) begin
                r_tx <= {1'b0, r_tx[SPI_DATA_W-1:1]};
              end
            end else begin
              r_sclk <= 1'b0;
              r_rx   <= {MISO, r_rx[SPI_DATA_W-1:1]};
              if (r_bit_cnt == LAST_BIT) begin
                r_state <= ST_HOLD;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_bit_cnt <= '0;
            r_cs      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_out  <= r_rx;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // MOSI is the flop holding the current TX bit, so it stays registered.
  assign MOSI               = r_tx[0];
  assign SCLK               = r_sclk;
  assign CS                 = r_cs;
  assign busy               = r_busy;
  assign done               = r_done;
  assign masterDataReceived = r_rx_out;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_a;
  logic       start_b;
  logic [7:0] tx_data;
  logic       miso;

  logic [7:0] rx_a, rx_b;
  logic       busy_a, done_a, sclk_a, cs_a, mosi_a;
  logic       busy_b, done_b, sclk_b, cs_b, mosi_b;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(2)) u_dut_a (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start_a),
    .masterDataToSend   (tx_data),
    .masterDataReceived (rx_a),
    .busy               (busy_a),
    .done               (done_a),
    .SCLK               (sclk_a),
    .CS                 (cs_a),
    .MOSI               (mosi_a),
    .MISO               (miso)
  );

  spi_master #(.CLK_DIV(1)) u_dut_b (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start_b),
    .masterDataToSend   (tx_data),
    .masterDataReceived (rx_b),
    .busy               (busy_b),
    .done               (done_b),
    .SCLK               (sclk_b),
    .CS                 (cs_b),
    .MOSI               (mosi_b),
    .MISO               (miso)
  );

  // sel picks which master the slave model talks to: 0 = CLK_DIV 2, 1 = CLK_DIV 1.
  logic       sel = 1'b0;
  logic       sclk_s, cs_s, mosi_s, busy_s, done_s;
  logic [7:0] rx_s;
  assign sclk_s = sel ? sclk_b : sclk_a;
  assign cs_s   = sel ? cs_b   : cs_a;
  assign mosi_s = sel ? mosi_b : mosi_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign rx_s   = sel ? rx_b   : rx_a;

  // Slave model: LSB first, drives bit 0 when CS falls, samples MOSI and
  // moves to the next bit on every SCLK fall.
  logic [7:0] s_reply = 8'h00;
  logic [7:0] s_sh    = 8'h00;
  logic [7:0] s_rx    = 8'h00;
  logic       s_miso  = 1'b0;
  logic       s_cs_d  = 1'b1;
  logic       tie_one = 1'b0;
  assign miso = tie_one ? 1'b1 : s_miso;

  always @(cs_s or negedge sclk_s) begin
    if (cs_s !== s_cs_d) begin
      if (cs_s === 1'b0) begin
        s_sh   <= s_reply;
        s_rx   <= 8'h00;
        s_miso <= s_reply[0];
      end
    end else if (cs_s === 1'b0 && sclk_s === 1'b0) begin
      s_rx   <= {mosi_s, s_rx[7:1]};
      s_sh   <= {1'b0, s_sh[7:1]};
      s_miso <= s_sh[1];
    end
    s_cs_d <= cs_s;
  end

  int cyc   = 0;
  int rises = 0;
  int falls = 0;
  always @(posedge clk)    cyc   <= cyc + 1;
  always @(posedge sclk_s) rises <= rises + 1;
  always @(negedge sclk_s) falls <= falls + 1;

  int   errors = 0;
  int   checks = 0;
  int   t0, r0, f0, d1, dedge;
  logic cs_at1, busy_at1, saw_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Edge 0 is the posedge just before start is driven; done_edge is -1 on timeout.
  task automatic run_xfer(input logic [7:0] data, input logic [7:0] reply,
                          input int pulse_at, output int done_edge);
    @(negedge clk);
    tx_data = data;
    s_reply = reply;
    t0 = cyc;
    r0 = rises;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    cs_at1   = cs_s;
    busy_at1 = busy_s;
    done_edge = -1;
    for (int i = 2; i < 200; i++) begin
      if (done_s === 1'b1) begin
        done_edge = cyc - t0;
        break;
      end
      set_start(i == pulse_at);
      @(negedge clk);
    end
    set_start(1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_a = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
    end
    check_eq("rst_cs",   32'(cs_a),   32'h1);
    check_eq("rst_sclk", 32'(sclk_a), 32'h0);
    check_eq("rst_mosi", 32'(mosi_a), 32'h0);
    check_eq("rst_busy", 32'(busy_a), 32'h0);
    check_eq("rst_done", 32'(done_a), 32'h0);
    check_eq("rst_rx",   32'(rx_a),   32'h00);
    @(negedge clk);
    start_a = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5 out, 0x3C back.
    run_xfer(8'hA5, 8'h3C, 0, dedge);
    check_eq("lb_cs_edge1",   32'(cs_at1),   32'h0);
    check_eq("lb_busy_edge1", 32'(busy_at1), 32'h1);
    check_eq("lb_done_edge",  32'(dedge),    32'd35);
    check_eq("lb_rx",         32'(rx_a),     32'h3C);
    check_eq("lb_slave_rx",   32'(s_rx),     32'hA5);
    check_eq("lb_rises",      32'(rises - r0), 32'd8);
    check_eq("lb_busy_done",  32'(busy_a),   32'h0);
    check_eq("lb_cs_done",    32'(cs_a),     32'h1);
    @(negedge clk);
    check_eq("lb_done_pulse", 32'(done_a),   32'h0);

    // Bit order: only bit 0 set, MISO tied high.
    tie_one = 1'b1;
    run_xfer(8'h01, 8'h00, 0, dedge);
    check_eq("bo_rx",       32'(rx_a), 32'hFF);
    check_eq("bo_mosi_bits", 32'(s_rx), 32'h01);
    tie_one = 1'b0;

    // Start pulse mid-transfer must be ignored and not queued.
    run_xfer(8'h96, 8'h69, 12, dedge);
    check_eq("bz_done_edge", 32'(dedge), 32'd35);
    check_eq("bz_rx",        32'(rx_a),  32'h69);
    check_eq("bz_slave_rx",  32'(s_rx),  32'h96);
    repeat (3) @(negedge clk);
    check_eq("bz_no_queue_busy", 32'(busy_a), 32'h0);
    check_eq("bz_no_queue_cs",   32'(cs_a),   32'h1);

    // Back-to-back with start held high.
    @(negedge clk);
    tx_data = 8'h12;
    s_reply = 8'hAB;
    start_a = 1'b1;
    d1 = -1000;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        d1 = cyc;
        break;
      end
    end
    check_eq("b2b_first_rx",  32'(rx_a), 32'hAB);
    check_eq("b2b_first_srx", 32'(s_rx), 32'h12);
    check_eq("b2b_cs_gap_hi", 32'(cs_a), 32'h1);
    tx_data = 8'h34;
    s_reply = 8'hCD;
    @(negedge clk);
    check_eq("b2b_cs_gap_lo", 32'(cs_a), 32'h0);
    start_a = 1'b0;
    dedge = -1;
    for (int i = 0; i < 200; i++) begin
      if (done_a === 1'b1) begin
        dedge = cyc - d1;
        break;
      end
      @(negedge clk);
    end
    check_eq("b2b_done_gap",   32'(dedge), 32'd35);
    check_eq("b2b_second_rx",  32'(rx_a),  32'hCD);
    check_eq("b2b_second_srx", 32'(s_rx),  32'h34);

    // Reset after the third falling edge.
    repeat (2) @(negedge clk);
    tx_data = 8'hE7;
    s_reply = 8'h81;
    f0 = falls;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 100 && (falls - f0) < 3; i++) @(negedge clk);
    check_eq("mid_fall3", 32'(falls - f0), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_cs_async", 32'(cs_a),   32'h1);
    check_eq("mid_busy",     32'(busy_a), 32'h0);
    check_eq("mid_sclk",     32'(sclk_a), 32'h0);
    check_eq("mid_rx_clr",   32'(rx_a),   32'h00);
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_a !== 1'b0) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_a !== 1'b0) saw_done = 1'b1;
    end
    check_eq("mid_no_done", 32'(saw_done), 32'h0);
    run_xfer(8'h5A, 8'h77, 0, dedge);
    check_eq("post_done_edge", 32'(dedge), 32'd35);
    check_eq("post_rx",        32'(rx_a),  32'h77);
    check_eq("post_slave_rx",  32'(s_rx),  32'h5A);

    // CLK_DIV = 1 instance.
    repeat (2) @(negedge clk);
    sel = 1'b1;
    repeat (2) @(negedge clk);
    run_xfer(8'hC7, 8'h2B, 0, dedge);
    check_eq("div1_done_edge", 32'(dedge),       32'd18);
    check_eq("div1_rx",        32'(rx_b),        32'h2B);
    check_eq("div1_slave_rx",  32'(s_rx),        32'hC7);
    check_eq("div1_rises",     32'(rises - r0),  32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
